// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer for the MIPS-style datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back and
// drives every datapath mux select, write enable and ALUOp. Memory accesses
// wait on mem_ready; an illegal opcode or a stalled memory parks the FSM in
// HALT with a sticky error flag until reset.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4 computed, IR/PC load on ready
// DECODE | read registers, branch target into ALUOut, dispatch on opcode
// MEMADR | base + offset for lw/sw
// MEMRD  | data read at ALUOut, wait for ready
// MEMWB  | memory data register written to rt
// MEMWR  | data write at ALUOut, wait for ready
// EXEC   | R-type ALU operation, funct decoded by ALUControl
// RWB    | R-type result written to rd
// BRANCH | beq compare, PC takes ALUOut when zero
// JUMP   | PC takes jump target
// ADDIEX | rs + sign-extended immediate
// ADDIWB | addi result written to rt
// HALT   | all enables off, waits for reset
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_out,
    output logic       error
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        HALT   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] waitCntNext;
    logic             setError;
    logic             isWaitState;
    logic             fetchDone;
    ctrl_t            ctrlQ;

    // Moore control word for a state; IRWrite and the FETCH PC load are Mealy
    // and handled separately so they follow mem_ready within the cycle.
    function automatic ctrl_t decodeCtrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
            DECODE: c.aluSrcB = 2'b11;
            MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEMRD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
            MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
            MEMWR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
            EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = 4'b0010; end
            RWB:    begin c.regWrite = 1'b1; c.regDst = 1'b1; end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 4'b0001;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
            end
            JUMP:   begin c.pcWrite = 1'b1; c.pcSource = 2'b10; end
            ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            ADDIWB: c.regWrite = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign isWaitState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    // Next state, wait-counter update and error detection.
    always_comb begin
        nextState   = state;
        setError    = 1'b0;
        waitCntNext = '0;
        case (state)
            FETCH:  if (mem_ready) nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    OP_ADDI:      nextState = ADDIEX;
                    default: begin
                        nextState = HALT;
                        setError  = 1'b1;
                    end
                endcase
            end
            MEMADR: nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) nextState = MEMWB;
            MEMWB:  nextState = FETCH;
            MEMWR:  if (mem_ready) nextState = FETCH;
            EXEC:   nextState = RWB;
            RWB:    nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
            ADDIEX: nextState = ADDIWB;
            ADDIWB: nextState = FETCH;
            HALT:   nextState = HALT;
            default: begin
                nextState = HALT;
                setError  = 1'b1;
            end
        endcase
        // A ready on the limit cycle wins; only a still-stalled request times out.
        if (isWaitState && !mem_ready) begin
            if (waitCnt == CNT_W'(WAIT_LIMIT)) begin
                nextState = HALT;
                setError  = 1'b1;
            end else begin
                waitCntNext = waitCnt + CNT_W'(1);
            end
        end
    end

    // State, wait counter, sticky error and the control word registered for the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            waitCnt <= '0;
            error   <= 1'b0;
            ctrlQ   <= decodeCtrl(FETCH);
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
            error   <= error | setError;
            ctrlQ   <= decodeCtrl(nextState);
        end
    end

    // The control register holds FETCH values through reset so the first
    // post-reset cycle fetches; gating with reset keeps every output low
    // while reset is held.
    assign fetchDone   = reset && (state == FETCH) && mem_ready;
    assign IRWrite     = fetchDone;
    assign PCWrite     = fetchDone | (reset & ctrlQ.pcWrite);
    assign PCWriteCond = reset & ctrlQ.pcWriteCond;
    assign IorD        = reset & ctrlQ.iorD;
    assign MemRead     = reset & ctrlQ.memRead;
    assign MemWrite    = reset & ctrlQ.memWrite;
    assign MemToReg    = reset & ctrlQ.memToReg;
    assign RegDst      = reset & ctrlQ.regDst;
    assign RegWrite    = reset & ctrlQ.regWrite;
    assign ALUSrcA     = reset & ctrlQ.aluSrcA;
    assign ALUSrcB     = ctrlQ.aluSrcB & {2{reset}};
    assign ALUOp       = ctrlQ.aluOp & {4{reset}};
    assign PCSource    = ctrlQ.pcSource & {2{reset}};
    assign state_out   = state;

endmodule
